// File: rtl/ws2811_pkg.sv
// Shared types for the WS2811 frame streamer: FSM state encoding, GRB pixel
// word layout and the latch-gap length helper.
package ws2811_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SEND,
        WAIT_ACK,
        WAIT_DONE,
        LATCH
    } state_e;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } grb_t;

    // Clamped to one cycle so a tiny clock or gap still produces a done pulse.
    function automatic int unsigned latch_cycles(input int unsigned clock_speed,
                                                 input int unsigned latch_us);
        int unsigned n;
        n = (clock_speed / 1_000_000) * latch_us;
        return (n == 0) ? 1 : n;
    endfunction

endpackage

// File: rtl/ws2811_brightness_scaler.sv
// Combinational per-channel brightness scaling: c_out = (c * (brightness + 1)) >> 8.
// brightness 255 leaves the word untouched, brightness 0 blanks it.
module ws2811_brightness_scaler
    import ws2811_pkg::*;
(
    input  grb_t       pix_in,
    input  logic [7:0] bright_in,
    output grb_t       pix_out
);

    logic [8:0] gain;

    function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [8:0] k);
        return 8'((16'(c) * 16'(k)) >> 8);
    endfunction

    // One 8x9 multiply per colour channel.
    always_comb begin
        gain      = 9'(bright_in) + 9'd1;
        pix_out.g = scale_chan(pix_in.g, gain);
        pix_out.r = scale_chan(pix_in.r, gain);
        pix_out.b = scale_chan(pix_in.b, gain);
    end

endmodule

// File: rtl/ws2811_frame_streamer.sv
// WS2811 frame streamer: walks a pixel memory, hands each GRB word to the
// serial transmitter, then holds the line low for the latch gap.
// Optional brightness scaling is enabled with WS2811_FRAME_STREAMER_BRIGHTNESS_EN.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   IDLE      | waiting for frameStartIN
//   FETCH     | address presented, waiting one cycle for memory read data
//   LOAD      | capture (optionally scaled) pixel word into txDataOUT
//   SEND      | wait for transmitter idle, then pulse txStartOUT
//   WAIT_ACK  | wait for transmitter to report busy
//   WAIT_DONE | wait for transmitter to finish; next pixel or latch gap
//   LATCH     | down-count latch gap, pulse frameDoneOUT on the last cycle
module ws2811_frame_streamer
    import ws2811_pkg::*;
#(
    parameter int UNITS_NUMBER = 100,
    parameter int CLOCK_SPEED  = 50_000_000,
    parameter int LATCH_US     = 60,
    // A single-pixel frame still needs a one-bit address port.
    localparam int AW = (UNITS_NUMBER > 1) ? $clog2(UNITS_NUMBER) : 1
) (
    input  logic          clkIN,
    input  logic          resetIN,
    input  logic          frameStartIN,
    output logic          frameBusyOUT,
    output logic          frameDoneOUT,
    output logic [AW-1:0] pixelAddrOUT,
    input  logic [23:0]   pixelDataIN,
`ifdef WS2811_FRAME_STREAMER_BRIGHTNESS_EN
    input  logic [7:0]    brightnessIN,
`endif
    output logic          txStartOUT,
    output logic [23:0]   txDataOUT,
    input  logic          txBusyIN
);

    localparam int unsigned    LATCH_CYCLES = latch_cycles(CLOCK_SPEED, LATCH_US);
    localparam int             LW           = $clog2(LATCH_CYCLES + 1);
    localparam logic [AW-1:0]  LAST_PIX     = AW'(UNITS_NUMBER - 1);
    localparam logic [LW-1:0]  LATCH_LOAD   = LW'(LATCH_CYCLES - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] pix_cnt_q, pix_cnt_d;
    logic [LW-1:0] latch_cnt_q, latch_cnt_d;
    grb_t          tx_data_q, tx_data_d;
    logic          tx_start_q, tx_start_d;

    grb_t          mem_word;
    grb_t          load_word;

    assign mem_word = pixelDataIN;

`ifdef WS2811_FRAME_STREAMER_BRIGHTNESS_EN
    ws2811_brightness_scaler u_scaler (
        .pix_in   (mem_word),
        .bright_in(brightnessIN),
        .pix_out  (load_word)
    );
`else
    assign load_word = mem_word;
`endif

    // Next-state and datapath updates; txStartOUT is registered so it can
    // only ever last one cycle (SEND always exits to WAIT_ACK).
    always_comb begin
        state_d     = state_q;
        pix_cnt_d   = pix_cnt_q;
        latch_cnt_d = latch_cnt_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (frameStartIN) begin
                    pix_cnt_d = '0;
                    state_d   = FETCH;
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                tx_data_d = load_word;
                state_d   = SEND;
            end
            SEND: begin
                if (!txBusyIN) begin
                    tx_start_d = 1'b1;
                    state_d    = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (txBusyIN) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!txBusyIN) begin
                    if (pix_cnt_q == LAST_PIX) begin
                        latch_cnt_d = LATCH_LOAD;
                        state_d     = LATCH;
                    end else begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                        state_d   = FETCH;
                    end
                end
            end
            LATCH: begin
                if (latch_cnt_q == '0) state_d = IDLE;
                else                   latch_cnt_d = latch_cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clkIN) begin
        if (resetIN) begin
            state_q     <= IDLE;
            pix_cnt_q   <= '0;
            latch_cnt_q <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_cnt_q   <= pix_cnt_d;
            latch_cnt_q <= latch_cnt_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
        end
    end

    assign frameBusyOUT = (state_q != IDLE);
    assign frameDoneOUT = (state_q == LATCH) && (latch_cnt_q == '0);
    assign pixelAddrOUT = pix_cnt_q;
    assign txStartOUT   = tx_start_q;
    assign txDataOUT    = tx_data_q;

endmodule
